note_player: RTL and testbench

- Sequencer that drives the sine_reader datapath for one note at a time.
- Accepts a note index and duration from the song sequencer.
- Fetches the note's phase step from the synchronous frequency ROM and presents it as step_size.
- Forwards codec sample requests as generate_next_sample pulses for the note's length in beats, then reports completion.

---
 rtl/note_player.sv | 87 ++++++++
 tb/tb_note_player.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Per-note sequencer for the sine_reader datapath: fetches the note's phase step
// from the frequency ROM, then issues sample-advance pulses for the note's beats.
module note_player #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              beat,
  input  logic              sample_req,
  output logic [NOTE_W-1:0] freq_addr,
  input  logic [STEP_W-1:0] freq_data,
  output logic [STEP_W-1:0] step_size,
  output logic              generate_next_sample,
  output logic              note_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  state_t           state, state_nxt;
  logic [DUR_W-1:0] dur_reg;
  logic [DUR_W-1:0] dur_cnt;
  logic             beat_en;
  logic             last_beat;

  // Beats only count while running; the last one ends the note instead of decrementing.
  assign beat_en   = beat & play_enable;
  assign last_beat = beat_en && (dur_cnt == DUR_ONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_new_note) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = (dur_reg == '0) ? DONE : PLAY;
      PLAY:    if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      freq_addr            <= '0;
      dur_reg              <= '0;
      dur_cnt              <= '0;
      step_size            <= '0;
      generate_next_sample <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && load_new_note) begin
        freq_addr <= note;
        dur_reg   <= duration;
      end

      // freq_data has had two edges to settle on freq_addr by the WAIT cycle.
      if (state == WAIT) begin
        step_size <= (freq_addr == '0) ? '0 : freq_data;
        dur_cnt   <= dur_reg;
      end else if (state == PLAY && beat_en && !last_beat) begin
        dur_cnt <= dur_cnt - DUR_ONE;
      end

      generate_next_sample <= (state == PLAY) && sample_req && play_enable;
    end
  end

  assign busy      = (state != IDLE);
  assign note_done = (state == DONE);

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a behavioural ROM and a scoreboard of
// expected generate_next_sample pulse cycles.
module tb_note_player;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int STEP_W = 20;

  logic              clk           = 1'b0;
  logic              reset         = 1'b0;
  logic              play_enable   = 1'b1;
  logic              load_new_note = 1'b0;
  logic [NOTE_W-1:0] note          = '0;
  logic [DUR_W-1:0]  duration      = '0;
  logic              beat          = 1'b0;
  logic              sample_req    = 1'b0;
  logic [NOTE_W-1:0] freq_addr;
  logic [STEP_W-1:0] freq_data;
  logic [STEP_W-1:0] step_size;
  logic              generate_next_sample;
  logic              note_done;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int exp_q[$];
  bit m_play    = 1'b0;
  int m_cnt     = 0;
  int m_done_at = -1;

  note_player #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .STEP_W(STEP_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note                 (note),
    .duration             (duration),
    .beat                 (beat),
    .sample_req           (sample_req),
    .freq_addr            (freq_addr),
    .freq_data            (freq_data),
    .step_size            (step_size),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [STEP_W-1:0] rom_val(input logic [NOTE_W-1:0] a);
    if (a == 6'd12) return 20'h0A3D7;
    return {a, 14'h1234};
  endfunction

  always @(posedge clk) freq_data <= rom_val(freq_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with optional beat/sample_req; updates the model, then checks pulses.
  task automatic tick(input logic b, input logic s);
    int   e;
    logic exp_g;
    beat       = b;
    sample_req = s;
    e          = cyc + 1;
    if (m_play && play_enable && s) exp_q.push_back(e);
    if (m_play && play_enable && b) begin
      if (m_cnt == 1) begin
        m_play    = 1'b0;
        m_done_at = e;
      end else begin
        m_cnt--;
      end
    end
    @(posedge clk);
    #1;
    beat          = 1'b0;
    sample_req    = 1'b0;
    load_new_note = 1'b0;
    exp_g = (exp_q.size() > 0 && exp_q[0] == cyc);
    if (exp_g) void'(exp_q.pop_front());
    check("gen_next_sample", {31'd0, generate_next_sample}, {31'd0, exp_g});
    check("note_done", {31'd0, note_done}, {31'd0, (cyc == m_done_at)});
  endtask

  task automatic load_note(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
    int l;
    note          = n;
    duration      = d;
    load_new_note = 1'b1;
    tick(1'b0, 1'b0);
    l = cyc;
    if (d == 0) m_done_at = l + 2;
    check("busy_fetch", {31'd0, busy}, 32'd1);
    tick(1'b0, 1'b1);
    check("busy_wait", {31'd0, busy}, 32'd1);
    tick(1'b0, 1'b1);
    if (d != 0) begin
      m_play = 1'b1;
      m_cnt  = int'(d);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_freq_addr", {26'd0, freq_addr}, 32'd0);
    check("rst_step_size", {12'd0, step_size}, 32'd0);
    check("rst_gns", {31'd0, generate_next_sample}, 32'd0);
    check("rst_note_done", {31'd0, note_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1'b0, 1'b1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Normal note 12, 3 beats; third beat coincides with a sample_req
    load_note(6'd12, 6'd3);
    check("n12_step", {12'd0, step_size}, 32'h0A3D7);
    check("n12_addr", {26'd0, freq_addr}, 32'd12);
    check("n12_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 120; i++) tick((i % 40) == 39, (i % 8) == 7);
    check("n12_busy_done", {31'd0, busy}, 32'd1);
    tick(1'b0, 1'b1);
    check("n12_busy_after", {31'd0, busy}, 32'd0);
    check("n12_q_empty", exp_q.size(), 32'd0);

    // Rest note, 2 beats
    load_note(6'd0, 6'd2);
    check("rest_step", {12'd0, step_size}, 32'd0);
    for (int i = 0; i < 80; i++) tick((i % 40) == 39, (i % 8) == 3);
    tick(1'b0, 1'b0);
    check("rest_busy_after", {31'd0, busy}, 32'd0);
    check("rest_q_empty", exp_q.size(), 32'd0);

    // Zero-duration note: FETCH/WAIT/DONE only
    load_note(6'd5, 6'd0);
    check("zero_busy_done", {31'd0, busy}, 32'd1);
    check("zero_step", {12'd0, step_size}, 32'h15234);
    tick(1'b0, 1'b1);
    check("zero_busy_after", {31'd0, busy}, 32'd0);

    // Pause with load attempt while busy
    load_note(6'd9, 6'd4);
    check("n9_step", {12'd0, step_size}, 32'h25234);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    note          = 6'd7;
    duration      = 6'd1;
    load_new_note = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("busy_load_step", {12'd0, step_size}, 32'h25234);
    check("busy_load_addr", {26'd0, freq_addr}, 32'd9);
    play_enable = 1'b0;
    for (int i = 0; i < 100; i++) tick((i % 10) == 0, (i % 3) == 0);
    check("pause_busy", {31'd0, busy}, 32'd1);
    play_enable = 1'b1;
    for (int i = 0; i < 60; i++) tick((i % 30) == 29, (i % 5) == 4);
    tick(1'b0, 1'b0);
    check("pause_busy_after", {31'd0, busy}, 32'd0);
    check("pause_q_empty", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a 5-beat note
    load_note(6'd3, 6'd5);
    tick(1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_freq_addr", {26'd0, freq_addr}, 32'd0);
    check("mid_rst_step", {12'd0, step_size}, 32'd0);
    check("mid_rst_gns", {31'd0, generate_next_sample}, 32'd0);
    check("mid_rst_note_done", {31'd0, note_done}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    m_play    = 1'b0;
    m_done_at = -1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick((i % 4) == 0, 1'b1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
